// File: rtl/fetch_ctrl.sv
// Fetch sequencer for the PC_IM stage: resolves branch/jump redirects, load-use stalls,
// post-redirect flushes and HLT/resume, and counts PC redirects.
module fetch_ctrl #(
  parameter logic [4:0] OP_JMP    = 5'h1E,
  parameter logic [4:0] OP_HLT    = 5'h1F,
  parameter int         FLUSH_CYC = 1,
  parameter int         LU_STALL  = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [19:0] ins_pm,
  input  logic        ex_branch_tkn,
  input  logic [7:0]  ex_branch_tgt,
  input  logic        ex_is_load,
  input  logic [4:0]  ex_rd,
  input  logic        resume,
  output logic [7:0]  jmp_loc,
  output logic        pc_mux_sel,
  output logic        stall,
  output logic        stall_pm,
  output logic        flush,
  output logic        halted,
  output logic [7:0]  redirect_cnt
);

  typedef enum logic [1:0] {S_RUN, S_STALL, S_FLUSH, S_HALT} state_t;

  // Counters preload to "remaining cycles - 1"; the RUN cycle that detects a
  // load-use hazard already counts as the first stalled cycle.
  localparam logic [1:0] FLUSH_INIT = 2'(FLUSH_CYC - 1);
  localparam logic [1:0] STALL_INIT = (LU_STALL > 1) ? 2'(LU_STALL - 2) : 2'd0;

  state_t      r_state, w_state_nxt;
  logic [1:0]  r_cnt, w_cnt_nxt;
  logic [7:0]  r_jmp_loc, r_redirect_cnt;
  logic [7:0]  w_tgt;
  logic        w_redirect, w_stall, w_flush, w_halted;
  logic        w_load_use;
  logic [4:0]  w_opcode;
  logic        w_unused_rd;

  assign w_opcode    = ins_pm[19:15];
  assign w_unused_rd = ^ins_pm[14:10];
  assign w_load_use  = ex_is_load && (ex_rd != 5'd0) &&
                       ((ex_rd == ins_pm[9:5]) || (ex_rd == ins_pm[4:0]));

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_redirect  = 1'b0;
    w_tgt       = r_jmp_loc;
    w_stall     = 1'b0;
    w_flush     = 1'b0;
    w_halted    = 1'b0;
    case (r_state)
      S_RUN: begin
        if (ex_branch_tkn) begin
          w_redirect  = 1'b1;
          w_tgt       = ex_branch_tgt;
          w_state_nxt = S_FLUSH;
          w_cnt_nxt   = FLUSH_INIT;
        end else if (w_load_use) begin
          w_stall = 1'b1;
          if (LU_STALL > 1) begin
            w_state_nxt = S_STALL;
            w_cnt_nxt   = STALL_INIT;
          end
        end else if (w_opcode == OP_JMP) begin
          w_redirect  = 1'b1;
          w_tgt       = ins_pm[7:0];
          w_state_nxt = S_FLUSH;
          w_cnt_nxt   = FLUSH_INIT;
        end else if (w_opcode == OP_HLT) begin
          w_stall     = 1'b1;
          w_state_nxt = S_HALT;
        end
      end
      S_STALL: begin
        if (ex_branch_tkn) begin
          w_redirect  = 1'b1;
          w_tgt       = ex_branch_tgt;
          w_state_nxt = S_FLUSH;
          w_cnt_nxt   = FLUSH_INIT;
        end else begin
          w_stall = 1'b1;
          if (r_cnt == 2'd0) w_state_nxt = S_RUN;
          else               w_cnt_nxt   = r_cnt - 2'd1;
        end
      end
      S_FLUSH: begin
        // The instruction in ID is being squashed, so only a new branch matters.
        w_flush = 1'b1;
        if (ex_branch_tkn) begin
          w_redirect = 1'b1;
          w_tgt      = ex_branch_tgt;
          w_cnt_nxt  = FLUSH_INIT;
        end else if (r_cnt == 2'd0) begin
          w_state_nxt = S_RUN;
        end else begin
          w_cnt_nxt = r_cnt - 2'd1;
        end
      end
      S_HALT: begin
        w_halted = 1'b1;
        if (resume) w_state_nxt = S_RUN;
        else        w_stall     = 1'b1;
      end
      default: w_state_nxt = S_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state        <= S_RUN;
      r_cnt          <= 2'd0;
      r_jmp_loc      <= 8'h00;
      r_redirect_cnt <= 8'h00;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_jmp_loc <= w_tgt;
      if (w_redirect && (r_redirect_cnt != 8'hFF))
        r_redirect_cnt <= r_redirect_cnt + 8'd1;
    end
  end

  assign jmp_loc      = w_tgt;
  assign pc_mux_sel   = !w_redirect;
  assign stall        = w_stall;
  assign stall_pm     = w_stall;
  assign flush        = w_flush;
  assign halted       = w_halted;
  assign redirect_cnt = r_redirect_cnt;

endmodule
